// File: rtl/dc_job_scheduler.sv
// dc_job_scheduler: queues host accelerator jobs and issues them to dc_router_top one at a time.
// Latency: a job accepted into an empty, idle scheduler raises chipselect two edges after acceptance.
// Backpressure: o_job_ready drops while DEPTH jobs wait in the queue (the active job is not counted).
//
// Ports:
//   i_clk, i_rst_n                      clock (rising edge), asynchronous active-low reset
//   i_job_valid / o_job_ready           job offer handshake
//   i_job_instruction/offset/filesize   job payload
//   i_abort                             flush the queue and terminate a running job
//   i_acc_done                          router completion
//   o_chipselect, o_instruction,
//   o_offset, o_filesize                router command interface
//   o_busy, o_queue_count               activity and queued-job count
//   o_done_pulse, o_bad_instr           one-cycle event pulses
//   o_timeout_err                       sticky watchdog flag
//   o_jobs_completed                    saturating completion counter

// dc_job_fifo: generic first-word-fall-through queue with synchronous flush.
// Latency: pushed data is visible at o_dat one edge after the push when the queue was empty.
// Backpressure: pushes while full and pops while empty are ignored; flush wins over push/pop.
module dc_job_fifo #(
   parameter int W     = 96,
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic             i_flush,
   input  logic [W-1:0]     i_dat,
   output logic [W-1:0]     o_dat,
   output logic [PTR_W:0]   o_count
);
   logic [W-1:0]     r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;
   logic             w_push;
   logic             w_pop;

   assign w_push = i_push && !i_flush && (r_count != (PTR_W+1)'(DEPTH));
   assign w_pop  = i_pop  && !i_flush && (r_count != '0);

   // Pointers are PTR_W bits wide, so they wrap modulo DEPTH on their own.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_dat;
   end

   assign o_dat   = r_mem[r_rd_ptr];
   assign o_count = r_count;
endmodule

module dc_job_scheduler #(
   parameter int DEPTH       = 4,
   parameter int PTR_W       = 2,
   parameter int HOLD_CYCLES = 8,
   parameter int GAP_CYCLES  = 5,
   parameter int TIMEOUT     = 65535
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_job_valid,
   output logic             o_job_ready,
   input  logic [31:0]      i_job_instruction,
   input  logic [31:0]      i_job_offset,
   input  logic [31:0]      i_job_filesize,
   input  logic             i_abort,
   input  logic             i_acc_done,
   output logic             o_chipselect,
   output logic [31:0]      o_instruction,
   output logic [31:0]      o_offset,
   output logic [31:0]      o_filesize,
   output logic             o_busy,
   output logic [PTR_W:0]   o_queue_count,
   output logic             o_done_pulse,
   output logic             o_bad_instr,
   output logic             o_timeout_err,
   output logic [15:0]      o_jobs_completed
);
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] offset;
      logic [31:0] fsize;
   } job_t;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HOLD, ST_GAP} state_t;

   localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT - 1);
   localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);
   localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);

   state_t         r_state;
   state_t         w_state_nxt;
   logic [15:0]    r_tick;
   job_t           r_job;
   logic           r_cs;
   logic           r_done;
   logic           r_bad;
   logic           r_tmo;
   logic [15:0]    r_jobs;

   job_t           w_in_job;
   job_t           w_head_job;
   logic [PTR_W:0] w_count;
   logic           w_opcode_ok;
   logic           w_accept;
   logic           w_push;
   logic           w_pop;
   logic           w_stop;
   logic           w_finish_ok;
   logic           w_finish_tmo;
   logic           w_clear;
   logic           w_tick_clr;

   assign w_in_job = {i_job_instruction, i_job_offset, i_job_filesize};

   // Accepted opcodes: FFT (001), FIR (011), IIR (111) under the 6'b111111 prefix.
   assign w_opcode_ok = (i_job_instruction[31:26] == 6'b111111) &&
                        ((i_job_instruction[2:0] == 3'b001) ||
                         (i_job_instruction[2:0] == 3'b011) ||
                         (i_job_instruction[2:0] == 3'b111));

   // Ready looks only at the registered count, so a same-cycle issue never opens a slot early.
   assign o_job_ready = (w_count != (PTR_W+1)'(DEPTH));
   // Abort discards any job offered in the same cycle; invalid jobs are consumed but dropped.
   assign w_accept    = i_job_valid && o_job_ready && !i_abort;
   assign w_push      = w_accept && w_opcode_ok;

   dc_job_fifo #(
      .W     ($bits(job_t)),
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (i_abort),
      .i_dat   (w_in_job),
      .o_dat   (w_head_job),
      .o_count (w_count)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_pop        = 1'b0;
      w_stop       = 1'b0;
      w_finish_ok  = 1'b0;
      w_finish_tmo = 1'b0;
      w_clear      = 1'b0;
      w_tick_clr   = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            // The queue is being flushed on abort, so nothing is issued that cycle.
            if ((w_count != '0) && !i_abort) begin
               w_pop       = 1'b1;
               w_tick_clr  = 1'b1;
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            // Priority: abort, then completion, then watchdog expiry.
            if (i_abort) begin
               w_stop = 1'b1;
            end else if (i_acc_done) begin
               w_stop      = 1'b1;
               w_finish_ok = 1'b1;
            end else if (r_tick == TMO_LAST) begin
               w_stop       = 1'b1;
               w_finish_tmo = 1'b1;
            end
            if (w_stop) begin
               w_tick_clr  = 1'b1;
               w_state_nxt = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (r_tick == HOLD_LAST) begin
               w_clear     = 1'b1;
               w_tick_clr  = 1'b1;
               w_state_nxt = ST_GAP;
            end
         end
         ST_GAP: begin
            if (r_tick == GAP_LAST) begin
               w_tick_clr  = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // One counter serves as RUN watchdog and HOLD/GAP phase timer.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)                 r_tick <= '0;
      else if (w_tick_clr)          r_tick <= '0;
      else if (r_state != ST_IDLE)  r_tick <= r_tick + 16'd1;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cs   <= 1'b0;
         r_job  <= '0;
         r_done <= 1'b0;
         r_bad  <= 1'b0;
         r_tmo  <= 1'b0;
         r_jobs <= '0;
      end else begin
         r_done <= w_finish_ok;
         r_bad  <= w_accept && !w_opcode_ok;
         if (w_pop) begin
            r_job <= w_head_job;
            r_cs  <= 1'b1;
         end else if (w_stop) begin
            r_cs  <= 1'b0;
         end
         if (w_clear)      r_job <= '0;
         if (w_finish_tmo) r_tmo <= 1'b1;
         if (w_finish_ok && (r_jobs != 16'hFFFF)) r_jobs <= r_jobs + 16'd1;
      end
   end

   assign o_chipselect     = r_cs;
   assign o_instruction    = r_job.instr;
   assign o_offset         = r_job.offset;
   assign o_filesize       = r_job.fsize;
   assign o_busy           = (r_state != ST_IDLE) || (w_count != '0);
   assign o_queue_count    = w_count;
   assign o_done_pulse     = r_done;
   assign o_bad_instr      = r_bad;
   assign o_timeout_err    = r_tmo;
   assign o_jobs_completed = r_jobs;
endmodule

// File: doc/dc_job_scheduler.md
Name: dc_job_scheduler

Overview:
- Host-side command scheduler that sits in front of dc_router_top.
- Accepts accelerator jobs (instruction, offset, filesize) into a small FIFO queue.
- Issues jobs to the router one at a time: drives chipselect/instruction/offset/filesize, waits for acc_done, then enforces the post-job hold and gap cycles before issuing the next job.
- Also provides a watchdog timeout, abort/flush and completion statistics.

Parameters:
- DEPTH, 4, job queue entries (power of 2, ≥2)
- PTR_W, 2, log2(DEPTH)
- HOLD_CYCLES, 8, cycles instruction/offset/filesize stay stable after chipselect drops
- GAP_CYCLES, 5, cycles with all router inputs zero before the next issue
- TIMEOUT, 65535, max RUN cycles without acc_done (≥1, fits 16 bits)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- job_valid  in  1  host offers a job this cycle
- job_ready  out  1  queue can accept (count < DEPTH)
- job_instruction  in  32  accelerator instruction word
- job_offset  in  32  RAM start offset
- job_filesize  in  32  transfer length
- abort  in  1  flush queue, terminate the current job
- acc_done  in  1  router job complete
- chipselect  out  1  router enable
- instruction  out  32  to router
- offset  out  32  to router
- filesize  out  32  to router
- busy  out  1  state != IDLE or count != 0
- queue_count  out  PTR_W+1  jobs queued, excluding the active job
- done_pulse  out  1  one-cycle pulse per completed job
- bad_instr  out  1  one-cycle pulse when a job is rejected
- timeout_err  out  1  sticky; cleared by reset only
- jobs_completed  out  16  saturating count of completed jobs

Behaviour:
- Reset (reset=0, async):
  - All outputs are 0, except job_ready=1.
  - Queue is emptied, pointers and counters are 0, FSM goes to IDLE.
  - Asserting reset mid-job drops chipselect immediately, with no hold/gap phase.
- Enqueue:
  - A job is accepted on a rising edge when job_valid & job_ready.
  - Valid opcodes: instruction[31:26]=6'b111111 and [2:0] ∈ {001 FFT, 011 FIR, 111 IIR}.
  - An invalid job is consumed (handshake completes) but not queued; bad_instr pulses the next cycle.
  - job_ready depends only on registered count, never on a same-cycle pop.
  - Simultaneous push and pop leaves count unchanged.
  - job_valid while full is ignored; no overwrite.
  - Pointers wrap modulo DEPTH.
- FSM:
  - IDLE: if count>0 → pop the head, register instruction/offset/filesize, set chipselect=1, → RUN. A job accepted at edge k into an empty queue gives chipselect=1 after edge k+1.
  - RUN:
    - Outputs are held stable; the watchdog counts up from 0.
    - acc_done=1 → chipselect=0, done_pulse=1 for one cycle, jobs_completed+1 (saturates at 0xFFFF), → HOLD.
    - Watchdog reaches TIMEOUT → timeout_err=1, chipselect=0, no done_pulse, no count, → HOLD.
    - If acc_done and the timeout occur on the same cycle, acc_done wins.
  - HOLD: chipselect=0; instruction/offset/filesize keep their values for HOLD_CYCLES cycles → GAP.
  - GAP: instruction/offset/filesize=0 for GAP_CYCLES cycles → IDLE. A queued job issues on the cycle after IDLE is entered.
- acc_done is ignored in IDLE, HOLD and GAP.
- abort (synchronous, one cycle, any state):
  - Queue count→0 and pointers reset.
  - In RUN: chipselect=0 → HOLD, with no done_pulse.
  - Other states continue their sequence.
  - An enqueue on the same cycle as abort is discarded.
- chipselect is never high outside RUN. Outputs are never changed while chipselect=1.

Test Plan:
1. Single FFT job: push {FC000001, 100, 40} into an empty queue → chipselect=1 two edges later with outputs {FC000001, 100, 40}; acc_done pulse → chipselect=0 next edge, done_pulse=1, outputs held 8 cycles, then zero for 5 cycles, jobs_completed=1.
2. Back-to-back FFT/FIR/IIR (FC000001, FC000003, FC000007) pushed on consecutive cycles → queue_count 1,2 then drains in order; each job is separated by exactly 8+5+1 cycles of chipselect=0; jobs_completed=3.
3. Fill and overflow: hold acc_done=0 and push DEPTH+2 jobs → 1 active + 4 queued, job_ready=0, the 6th job is not accepted, queue_count=4; simultaneous push and pop at count=4 is impossible (ready=0), at count=3 the count stays 3.
4. Invalid opcode FC000002 → accepted, bad_instr=1 for one cycle, queue_count unchanged, chipselect stays 0.
5. Timeout with TIMEOUT=16: no acc_done → chipselect drops after 16 RUN cycles, timeout_err=1 (sticky), done_pulse=0, next queued job still issues after HOLD+GAP.
6. abort during RUN with 2 queued → chipselect=0 next edge, queue_count=0; async reset asserted mid-RUN → all outputs 0 immediately, job_ready=1.
